// File: rtl/cu_multicycle.sv
// Multi-cycle RV32I control unit: sequences FETCH/DECODE/EXEC/MEM/WB with ready-handshaked
// instruction and data memories, counts retired instructions and traps on illegal opcode or timeout.
module cu_multicycle #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [6:0]       opcode,
    input  logic [2:0]       funct3,
    input  logic [6:0]       funct7,
    input  logic             ImReady,
    input  logic             DmReady,
    output logic             ImReq,
    output logic             IRWr,
    output logic             PCWr,
    output logic             RUWr,
    output logic [2:0]       ImmSrc,
    output logic             AluAsrc,
    output logic             AluBsrc,
    output logic [4:0]       BrOp,
    output logic [3:0]       AluOp,
    output logic             DmReq,
    output logic             DmWr,
    output logic [2:0]       DmCtrl,
    output logic [1:0]       RUDataWrSrc,
    output logic             Trap,
    output logic [CNT_W-1:0] InstRet
);

    localparam int WAIT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(TIMEOUT);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd5
    } state_t;

    state_t            r_state;
    logic [WAIT_W-1:0] r_wait;
    logic [CNT_W-1:0]  r_instret;

    logic w_r, w_i, w_ld, w_st, w_br, w_jal, w_jalr, w_lui, w_auipc;
    logic w_legal, w_dec_on, w_timeout, w_pcwr, w_unused;

    assign w_r     = (opcode == 7'b0110011);
    assign w_i     = (opcode == 7'b0010011);
    assign w_ld    = (opcode == 7'b0000011);
    assign w_st    = (opcode == 7'b0100011);
    assign w_br    = (opcode == 7'b1100011);
    assign w_jal   = (opcode == 7'b1101111);
    assign w_jalr  = (opcode == 7'b1100111);
    assign w_lui   = (opcode == 7'b0110111);
    assign w_auipc = (opcode == 7'b0010111);
    assign w_legal = |{w_r, w_i, w_ld, w_st, w_br, w_jal, w_jalr, w_lui, w_auipc};

    // Only funct7[5] distinguishes operations (SUB/SRA/SRAI); the rest of the field is don't-care.
    assign w_unused = ^{funct7[6], funct7[4:0]};

    assign w_dec_on  = (r_state == S_DECODE) || (r_state == S_EXEC) ||
                       (r_state == S_MEM)    || (r_state == S_WB);
    assign w_timeout = (TIMEOUT != 0) && (r_wait == WAIT_MAX);

    // Retirement happens on the last cycle of every instruction class.
    assign w_pcwr = ((r_state == S_EXEC) && w_br) ||
                    ((r_state == S_MEM) && w_st && DmReady) ||
                    (r_state == S_WB);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_FETCH;
            r_wait    <= '0;
            r_instret <= '0;
        end else begin
            if (w_pcwr)
                r_instret <= r_instret + CNT_W'(1);
            case (r_state)
                S_FETCH: begin
                    if (ImReady) begin
                        r_state <= S_DECODE;
                        r_wait  <= '0;
                    end else if (w_timeout) begin
                        r_state <= S_TRAP;
                        r_wait  <= '0;
                    end else begin
                        r_wait  <= r_wait + WAIT_W'(1);
                    end
                end
                S_DECODE: begin
                    r_wait  <= '0;
                    r_state <= w_legal ? S_EXEC : S_TRAP;
                end
                S_EXEC: begin
                    r_wait <= '0;
                    if (w_br)
                        r_state <= S_FETCH;
                    else if (w_ld || w_st)
                        r_state <= S_MEM;
                    else
                        r_state <= S_WB;
                end
                S_MEM: begin
                    if (DmReady) begin
                        r_state <= w_ld ? S_WB : S_FETCH;
                        r_wait  <= '0;
                    end else if (w_timeout) begin
                        r_state <= S_TRAP;
                        r_wait  <= '0;
                    end else begin
                        r_wait  <= r_wait + WAIT_W'(1);
                    end
                end
                S_WB: begin
                    r_wait  <= '0;
                    r_state <= S_FETCH;
                end
                S_TRAP: begin
                    r_wait  <= '0;
                    r_state <= S_TRAP;
                end
                default: begin
                    r_wait  <= '0;
                    r_state <= S_FETCH;
                end
            endcase
        end
    end

    always_comb begin
        ImReq       = 1'b0;
        IRWr        = 1'b0;
        RUWr        = 1'b0;
        DmReq       = 1'b0;
        DmWr        = 1'b0;
        Trap        = 1'b0;
        PCWr        = w_pcwr;
        ImmSrc      = 3'b000;
        AluAsrc     = 1'b0;
        AluBsrc     = 1'b0;
        BrOp        = 5'b00000;
        AluOp       = 4'b0000;
        DmCtrl      = 3'b000;
        RUDataWrSrc = 2'b00;

        case (r_state)
            S_FETCH: begin
                ImReq = rst_n;
                IRWr  = rst_n && ImReady;
            end
            S_MEM: begin
                DmReq = 1'b1;
                DmWr  = w_st;
            end
            S_WB:    RUWr = 1'b1;
            S_TRAP:  Trap = 1'b1;
            default: ;
        endcase

        if (w_dec_on) begin
            if (w_st)
                ImmSrc = 3'b001;
            else if (w_br)
                ImmSrc = 3'b101;
            else if (w_lui || w_auipc)
                ImmSrc = 3'b010;
            else if (w_jal)
                ImmSrc = 3'b110;

            AluAsrc = w_br || w_jal || w_auipc;
            AluBsrc = w_legal && !w_r;

            if (w_br)
                BrOp = {2'b01, funct3};
            else if (w_jal || w_jalr)
                BrOp = 5'b10000;

            // LUI uses 1111 (pass operand B) because its rs1 field holds immediate bits.
            if (w_r)
                AluOp = {funct7[5], funct3};
            else if (w_i)
                AluOp = {(funct3 == 3'b101) && funct7[5], funct3};
            else if (w_lui)
                AluOp = 4'b1111;

            if (w_ld || w_st)
                DmCtrl = funct3;

            if (w_ld)
                RUDataWrSrc = 2'b01;
            else if (w_jal || w_jalr)
                RUDataWrSrc = 2'b10;
        end
    end

    assign InstRet = r_instret;

endmodule

// File: tb/tb_cu_multicycle.sv
// Bench for cu_multicycle: directed instruction table, wait-state/timeout/trap/reset sequences,
// and randomized instructions checked against a per-instruction cycle-trace model.
module tb_cu_multicycle;

    localparam int TMO  = 16;
    localparam int K_WB = 0, K_BR = 1, K_LD = 2, K_ST = 3, K_ILL = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [6:0] opcode = '0;
    logic [2:0] funct3 = '0;
    logic [6:0] funct7 = '0;
    logic       ImReady = 1'b0;
    logic       DmReady = 1'b0;
    logic       ImReq, IRWr, PCWr, RUWr, AluAsrc, AluBsrc, DmReq, DmWr, Trap;
    logic [2:0] ImmSrc, DmCtrl;
    logic [4:0] BrOp;
    logic [3:0] AluOp;
    logic [1:0] RUDataWrSrc;
    logic [3:0] InstRet;

    typedef struct packed {
        logic [2:0] imm;
        logic       asrc;
        logic       bsrc;
        logic [4:0] br;
        logic [3:0] alu;
        logic [2:0] dm;
        logic [1:0] wr;
    } dec_t;

    typedef struct {
        string      name;
        logic [6:0] op;
        logic [2:0] f3;
        logic [6:0] f7;
        int         fw;
        int         mw;
        dec_t       dec;
        int         lat;
    } vec_t;

    int   n_checks = 0;
    int   n_errors = 0;
    int   retired  = 0;
    vec_t tbl[$];

    logic [6:0] act_strb;
    dec_t       act_dec;
    assign act_strb = {ImReq, IRWr, PCWr, RUWr, DmReq, DmWr, Trap};
    assign act_dec  = {ImmSrc, AluAsrc, AluBsrc, BrOp, AluOp, DmCtrl, RUDataWrSrc};

    cu_multicycle #(.TIMEOUT(TMO), .CNT_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct3(funct3), .funct7(funct7),
        .ImReady(ImReady), .DmReady(DmReady), .ImReq(ImReq), .IRWr(IRWr), .PCWr(PCWr),
        .RUWr(RUWr), .ImmSrc(ImmSrc), .AluAsrc(AluAsrc), .AluBsrc(AluBsrc), .BrOp(BrOp),
        .AluOp(AluOp), .DmReq(DmReq), .DmWr(DmWr), .DmCtrl(DmCtrl),
        .RUDataWrSrc(RUDataWrSrc), .Trap(Trap), .InstRet(InstRet)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [6:0] S(input logic imreq, input logic irwr, input logic pcwr,
                                     input logic ruwr, input logic dmreq, input logic dmwr,
                                     input logic trap);
        return {imreq, irwr, pcwr, ruwr, dmreq, dmwr, trap};
    endfunction

    function automatic dec_t D(input logic [2:0] imm, input logic a, input logic b,
                               input logic [4:0] br, input logic [3:0] alu,
                               input logic [2:0] dm, input logic [1:0] wr);
        dec_t d;
        d.imm = imm; d.asrc = a; d.bsrc = b; d.br = br; d.alu = alu; d.dm = dm; d.wr = wr;
        return d;
    endfunction

    function automatic int ref_kind(input logic [6:0] op);
        case (op)
            7'b1100011: return K_BR;
            7'b0000011: return K_LD;
            7'b0100011: return K_ST;
            7'b0110011, 7'b0010011, 7'b1101111, 7'b1100111,
            7'b0110111, 7'b0010111: return K_WB;
            default: return K_ILL;
        endcase
    endfunction

    function automatic int ref_lat(input logic [6:0] op);
        case (ref_kind(op))
            K_BR:    return 3;
            K_LD:    return 5;
            default: return 4;
        endcase
    endfunction

    function automatic dec_t ref_dec(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7);
        dec_t d;
        d = '0;
        case (op)
            7'b0110011: d.alu = {f7[5], f3};
            7'b0010011: begin d.bsrc = 1'b1; d.alu = {(f3 == 3'b101) ? f7[5] : 1'b0, f3}; end
            7'b0000011: begin d.bsrc = 1'b1; d.dm = f3; d.wr = 2'b01; end
            7'b0100011: begin d.imm = 3'b001; d.bsrc = 1'b1; d.dm = f3; end
            7'b1100011: begin d.imm = 3'b101; d.asrc = 1'b1; d.bsrc = 1'b1; d.br = {2'b01, f3}; end
            7'b1101111: begin d.imm = 3'b110; d.asrc = 1'b1; d.bsrc = 1'b1; d.br = 5'b10000; d.wr = 2'b10; end
            7'b1100111: begin d.bsrc = 1'b1; d.br = 5'b10000; d.wr = 2'b10; end
            7'b0110111: begin d.imm = 3'b010; d.bsrc = 1'b1; d.alu = 4'b1111; end
            7'b0010111: begin d.imm = 3'b010; d.asrc = 1'b1; d.bsrc = 1'b1; end
            default: ;
        endcase
        return d;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic cyc_chk(input string nm, input logic [6:0] es, input dec_t ed);
        chk({nm, ".strobes"}, 32'(act_strb), 32'(es));
        chk({nm, ".fields"},  32'(act_dec),  32'(ed));
        chk({nm, ".instret"}, 32'(InstRet),  32'(retired % 16));
    endtask

    task automatic rand_ready();
        ImReady = 1'($urandom);
        DmReady = 1'($urandom);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        rand_ready();
        #3;
        chk("reset.strobes", 32'(act_strb), 32'(0));
        chk("reset.fields",  32'(act_dec),  32'(0));
        chk("reset.instret", 32'(InstRet),  32'(0));
        @(posedge clk); #1;
        rst_n   = 1'b1;
        retired = 0;
    endtask

    // One instruction: fw fetch wait cycles, mw memory wait cycles, expected decode fields ed,
    // zero-wait latency lat.  Waits beyond TMO are expected to end in TRAP.
    task automatic run_instr(input string nm, input logic [6:0] op, input logic [2:0] f3,
                             input logic [6:0] f7, input int fw, input int mw,
                             input dec_t ed, input int lat);
        int   kind;
        int   cyc;
        int   dut_ret;
        bit   trapped;
        logic pw;
        dec_t z;
        kind = ref_kind(op); cyc = 0; dut_ret = -1; trapped = 0; z = '0;

        for (int i = 0; i <= TMO; i++) begin
            ImReady = (i >= fw);
            DmReady = 1'($urandom);
            opcode = 7'($urandom); funct3 = 3'($urandom); funct7 = 7'($urandom);
            @(negedge clk);
            cyc++;
            cyc_chk({nm, ".fetch"}, S(1, ImReady, 0, 0, 0, 0, 0), z);
            @(posedge clk); #1;
            if (ImReady) break;
            if (i == TMO) trapped = 1;
        end

        if (!trapped) begin
            opcode = op; funct3 = f3; funct7 = f7;
            rand_ready();
            @(negedge clk);
            cyc++;
            cyc_chk({nm, ".decode"}, S(0, 0, 0, 0, 0, 0, 0), ed);
            @(posedge clk); #1;
            if (kind == K_ILL) trapped = 1;
        end

        if (!trapped) begin
            pw = (kind == K_BR);
            rand_ready();
            @(negedge clk);
            cyc++;
            cyc_chk({nm, ".exec"}, S(0, 0, pw, 0, 0, 0, 0), ed);
            if (PCWr === 1'b1 && dut_ret < 0) dut_ret = cyc;
            @(posedge clk); #1;
            if (pw) retired++;
        end

        if (!trapped && (kind == K_LD || kind == K_ST)) begin
            for (int j = 0; j <= TMO; j++) begin
                DmReady = (j >= mw);
                ImReady = 1'($urandom);
                pw = (kind == K_ST) && DmReady;
                @(negedge clk);
                cyc++;
                cyc_chk({nm, ".mem"}, S(0, 0, pw, 0, 1, kind == K_ST, 0), ed);
                if (PCWr === 1'b1 && dut_ret < 0) dut_ret = cyc;
                @(posedge clk); #1;
                if (pw) retired++;
                if (DmReady) break;
                if (j == TMO) trapped = 1;
            end
        end

        if (!trapped && (kind == K_WB || kind == K_LD)) begin
            rand_ready();
            @(negedge clk);
            cyc++;
            cyc_chk({nm, ".wb"}, S(0, 0, 1, 1, 0, 0, 0), ed);
            if (PCWr === 1'b1 && dut_ret < 0) dut_ret = cyc;
            @(posedge clk); #1;
            retired++;
        end

        if (!trapped) begin
            chk({nm, ".latency"}, 32'(dut_ret),
                32'(lat + fw + ((kind == K_LD || kind == K_ST) ? mw : 0)));
        end else begin
            for (int k = 0; k < 3; k++) begin
                rand_ready();
                @(negedge clk);
                cyc_chk({nm, ".trap"}, S(0, 0, 0, 0, 0, 0, 1), z);
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic add(input string n, input logic [6:0] op, input logic [2:0] f3,
                       input logic [6:0] f7, input int fw, input int mw,
                       input dec_t d, input int lat);
        vec_t v;
        v.name = n; v.op = op; v.f3 = f3; v.f7 = f7; v.fw = fw; v.mw = mw; v.dec = d; v.lat = lat;
        tbl.push_back(v);
    endtask

    initial begin
        logic [6:0] legal_ops [9];
        legal_ops = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
                      7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111};

        add("ADD",    7'b0110011, 3'b000, 7'b0000000, 0,  0,  D(3'b000,0,0,5'b00000,4'b0000,3'b000,2'b00), 4);
        add("SUB",    7'b0110011, 3'b000, 7'b0100000, 0,  0,  D(3'b000,0,0,5'b00000,4'b1000,3'b000,2'b00), 4);
        add("SRA",    7'b0110011, 3'b101, 7'b0100000, 1,  0,  D(3'b000,0,0,5'b00000,4'b1101,3'b000,2'b00), 4);
        add("ADDI",   7'b0010011, 3'b000, 7'b0100000, 0,  0,  D(3'b000,0,1,5'b00000,4'b0000,3'b000,2'b00), 4);
        add("SRAI",   7'b0010011, 3'b101, 7'b0100000, 0,  0,  D(3'b000,0,1,5'b00000,4'b1101,3'b000,2'b00), 4);
        add("SLLI",   7'b0010011, 3'b001, 7'b0000000, 2,  0,  D(3'b000,0,1,5'b00000,4'b0001,3'b000,2'b00), 4);
        add("LW",     7'b0000011, 3'b010, 7'b0000000, 0,  3,  D(3'b000,0,1,5'b00000,4'b0000,3'b010,2'b01), 5);
        add("LBU",    7'b0000011, 3'b100, 7'b0000000, 0,  0,  D(3'b000,0,1,5'b00000,4'b0000,3'b100,2'b01), 5);
        add("SW",     7'b0100011, 3'b010, 7'b0000000, 0,  2,  D(3'b001,0,1,5'b00000,4'b0000,3'b010,2'b00), 4);
        add("SB",     7'b0100011, 3'b000, 7'b0000000, 0,  0,  D(3'b001,0,1,5'b00000,4'b0000,3'b000,2'b00), 4);
        add("BEQ",    7'b1100011, 3'b000, 7'b0000000, 0,  0,  D(3'b101,1,1,5'b01000,4'b0000,3'b000,2'b00), 3);
        add("BNE",    7'b1100011, 3'b001, 7'b0000000, 2,  0,  D(3'b101,1,1,5'b01001,4'b0000,3'b000,2'b00), 3);
        add("JAL",    7'b1101111, 3'b000, 7'b0000000, 0,  0,  D(3'b110,1,1,5'b10000,4'b0000,3'b000,2'b10), 4);
        add("JALR",   7'b1100111, 3'b000, 7'b0000000, 0,  0,  D(3'b000,0,1,5'b10000,4'b0000,3'b000,2'b10), 4);
        add("LUI",    7'b0110111, 3'b011, 7'b0100000, 0,  0,  D(3'b010,0,1,5'b00000,4'b1111,3'b000,2'b00), 4);
        add("AUIPC",  7'b0010111, 3'b000, 7'b0000000, 0,  0,  D(3'b010,1,1,5'b00000,4'b0000,3'b000,2'b00), 4);
        add("ADD_f16",7'b0110011, 3'b000, 7'b0000000, 16, 0,  D(3'b000,0,0,5'b00000,4'b0000,3'b000,2'b00), 4);
        add("LW_m16", 7'b0000011, 3'b010, 7'b0000000, 0,  16, D(3'b000,0,1,5'b00000,4'b0000,3'b010,2'b01), 5);

        do_reset();
        // 18 retirements with a 4-bit counter exercise the modulo wrap.
        foreach (tbl[n])
            run_instr(tbl[n].name, tbl[n].op, tbl[n].f3, tbl[n].f7, tbl[n].fw, tbl[n].mw,
                      tbl[n].dec, tbl[n].lat);

        run_instr("ILLEGAL", 7'b1111111, 3'b000, 7'b0000000, 0, 0, '0, 0);
        do_reset();
        run_instr("IM_TIMEOUT", 7'b0110011, 3'b000, 7'b0000000, 17, 0, '0, 0);
        do_reset();
        run_instr("ADD_pre", 7'b0110011, 3'b000, 7'b0000000, 0, 0, ref_dec(7'b0110011, 3'b000, 7'b0), 4);
        run_instr("DM_TIMEOUT", 7'b0000011, 3'b010, 7'b0000000, 0, 17, ref_dec(7'b0000011, 3'b010, 7'b0), 5);
        chk("dm_timeout.instret_frozen", 32'(InstRet), 32'(1));
        do_reset();

        for (int n = 0; n < 40; n++) begin
            logic [6:0] op;
            logic [2:0] f3;
            logic [6:0] f7;
            op = legal_ops[$urandom_range(0, 8)];
            f3 = 3'($urandom);
            f7 = 7'($urandom);
            run_instr($sformatf("rnd%0d", n), op, f3, f7, $urandom_range(0, 3),
                      $urandom_range(0, 3), ref_dec(op, f3, f7), ref_lat(op));
        end

        // Reset while a store is waiting in MEM.
        rand_ready();
        ImReady = 1'b1;
        @(posedge clk); #1;
        opcode = 7'b0100011; funct3 = 3'b010; funct7 = 7'b0;
        ImReady = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        DmReady = 1'b0;
        @(negedge clk);
        chk("midmem.strobes", 32'(act_strb), 32'(S(0, 0, 0, 0, 1, 1, 0)));
        #2 rst_n = 1'b0;
        #1;
        chk("midmem.rst.strobes", 32'(act_strb), 32'(0));
        chk("midmem.rst.instret", 32'(InstRet), 32'(0));
        @(posedge clk); #1;
        rst_n   = 1'b1;
        retired = 0;
        run_instr("post_rst_ADD", 7'b0110011, 3'b000, 7'b0000000, 0, 0,
                  D(3'b000,0,0,5'b00000,4'b0000,3'b000,2'b00), 4);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
